// File: rtl/trdb_pkg.sv
// Shared types, sizes and frame helpers for the trace encapsulator.
package trdb_pkg;

    typedef enum logic {ENC_IDLE, ENC_SEND} encap_state_e;

    localparam int unsigned ENCAP_HDR_BYTES     = 1;
    localparam int unsigned ENCAP_MAX_PKT_BYTES = 16;
    localparam int unsigned ENCAP_MAX_BEATS     = 5;
    localparam int unsigned ENCAP_BEAT_BYTES    = 4;
    localparam int unsigned ENCAP_LEN_W         = 5;
    localparam int unsigned ENCAP_BEATS_W       = 3;
    localparam int unsigned ENCAP_DATA_W        = ENCAP_MAX_PKT_BYTES * 8;
    localparam int unsigned ENCAP_FRAME_W       = ENCAP_MAX_BEATS * ENCAP_BEAT_BYTES * 8;

    // Queued packet: clamped byte length plus payload.
    typedef struct packed {
        logic [ENCAP_LEN_W-1:0]  len;
        logic [ENCAP_DATA_W-1:0] data;
    } encap_pkt_t;

    // Header byte followed by the first len payload bytes; everything above is zero.
    function automatic logic [ENCAP_FRAME_W-1:0] encap_build_frame(input encap_pkt_t pkt);
        logic [ENCAP_FRAME_W-1:0] frame;
        frame      = '0;
        frame[7:0] = {3'b000, pkt.len};
        for (int unsigned i = 0; i < ENCAP_MAX_PKT_BYTES; i++) begin
            if (ENCAP_LEN_W'(i) < pkt.len) begin
                frame[8*(i+1) +: 8] = pkt.data[8*i +: 8];
            end
        end
        return frame;
    endfunction

    // Beats needed for header plus len bytes, rounded up to whole beats.
    function automatic logic [ENCAP_BEATS_W-1:0] encap_beat_count(input logic [ENCAP_LEN_W-1:0] len);
        logic [ENCAP_LEN_W:0] sum;
        sum = (ENCAP_LEN_W+1)'(len) + (ENCAP_LEN_W+1)'(ENCAP_HDR_BYTES + ENCAP_BEAT_BYTES - 1);
        return ENCAP_BEATS_W'(sum >> 2);
    endfunction

endpackage

// File: rtl/trdb_fifo.sv
// Generic synchronous FIFO with occupancy count; DEPTH must be a power of two.
module trdb_fifo #(
    parameter int unsigned WIDTH = 133,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata_c,
    output logic                       full_c,
    output logic                       empty_c,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_c  = (count_q == CNT_W'(DEPTH));
    assign empty_c = (count_q == '0);
    assign push_ok = push && !full_c;
    assign pop_ok  = pop && !empty_c;
    assign rdata_c = mem[rd_ptr_q];
    assign count   = count_q;

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/trdb_encapsulator.sv
// Queues trace packets, frames each with a length header and streams it as 32-bit beats.
module trdb_encapsulator
    import trdb_pkg::*;
#(
    parameter int unsigned PKT_W = 128,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned HI_WM = 6,
    parameter int unsigned LO_WM = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       pkt_valid_i,
    input  logic [4:0]                 pkt_length_i,
    input  logic [PKT_W-1:0]           pkt_data_i,
    output logic                       encapsulator_ready_o,
    output logic                       pkt_drop_o,
    output logic [$clog2(DEPTH+1)-1:0] fill_o,
    output logic                       beat_valid_o,
    output logic [OUT_W-1:0]           beat_data_o,
    output logic                       beat_last_o,
    input  logic                       beat_ready_i
);

    localparam int unsigned FILL_W = $clog2(DEPTH+1);

    encap_state_e             state_q, state_d;
    logic [ENCAP_FRAME_W-1:0] frame_q, frame_d;
    logic [ENCAP_BEATS_W-1:0] left_q, left_d;
    logic                     valid_q, valid_d;
    logic [OUT_W-1:0]         data_q, data_d;
    logic                     last_q, last_d;
    logic                     ready_q, ready_d;
    logic                     drop_q, drop_d;

    logic [ENCAP_LEN_W-1:0]   len_clamp_c;
    logic                     pkt_req_c;
    logic                     push_c;
    logic                     pop_c;
    encap_pkt_t               wr_pkt_c;
    encap_pkt_t               rd_pkt_c;
    logic                     full_c;
    logic                     empty_c;
    logic [ENCAP_FRAME_W-1:0] load_frame_c;
    logic [ENCAP_BEATS_W-1:0] load_beats_c;
    logic [FILL_W-1:0]        fill_nxt_c;

    // Length clamp and push/drop decision against the pre-edge full flag.
    always_comb begin
        len_clamp_c   = (pkt_length_i > 5'd16) ? ENCAP_LEN_W'(ENCAP_MAX_PKT_BYTES) : pkt_length_i;
        pkt_req_c     = pkt_valid_i && (pkt_length_i != 5'd0);
        push_c        = pkt_req_c && !full_c;
        drop_d        = pkt_req_c && full_c;
        wr_pkt_c.len  = len_clamp_c;
        wr_pkt_c.data = ENCAP_DATA_W'(pkt_data_i);
    end

    trdb_fifo #(
        .WIDTH ($bits(encap_pkt_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push    (push_c),
        .wdata   (wr_pkt_c),
        .pop     (pop_c),
        .rdata_c (rd_pkt_c),
        .full_c  (full_c),
        .empty_c (empty_c),
        .count   (fill_o)
    );

    assign load_frame_c = encap_build_frame(rd_pkt_c);
    assign load_beats_c = encap_beat_count(rd_pkt_c.len);

    // Serializer next state: frame_q always holds the current beat in its low word.
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        left_d  = left_q;
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        pop_c   = 1'b0;

        unique case (state_q)
            ENC_IDLE: begin
                if (!empty_c) begin
                    pop_c   = 1'b1;
                    state_d = ENC_SEND;
                    frame_d = load_frame_c;
                    left_d  = load_beats_c;
                    valid_d = 1'b1;
                    data_d  = load_frame_c[OUT_W-1:0];
                    last_d  = (load_beats_c == ENCAP_BEATS_W'(1));
                end
            end
            ENC_SEND: begin
                if (valid_q && beat_ready_i) begin
                    if (last_q) begin
                        if (!empty_c) begin
                            pop_c   = 1'b1;
                            frame_d = load_frame_c;
                            left_d  = load_beats_c;
                            valid_d = 1'b1;
                            data_d  = load_frame_c[OUT_W-1:0];
                            last_d  = (load_beats_c == ENCAP_BEATS_W'(1));
                        end else begin
                            state_d = ENC_IDLE;
                            frame_d = '0;
                            left_d  = '0;
                            valid_d = 1'b0;
                            data_d  = '0;
                            last_d  = 1'b0;
                        end
                    end else begin
                        frame_d = frame_q >> OUT_W;
                        left_d  = left_q - ENCAP_BEATS_W'(1);
                        data_d  = frame_d[OUT_W-1:0];
                        last_d  = (left_q == ENCAP_BEATS_W'(2));
                    end
                end
            end
            default: state_d = ENC_IDLE;
        endcase
    end

    // Ready hysteresis on the post-edge fill level.
    always_comb begin
        ready_d    = ready_q;
        fill_nxt_c = fill_o + FILL_W'(push_c) - FILL_W'(pop_c);
        if (fill_nxt_c >= FILL_W'(HI_WM)) begin
            ready_d = 1'b0;
        end else if (fill_nxt_c <= FILL_W'(LO_WM)) begin
            ready_d = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ENC_IDLE;
            frame_q <= '0;
            left_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            ready_q <= 1'b1;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            left_q  <= left_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            ready_q <= ready_d;
            drop_q  <= drop_d;
        end
    end

    assign encapsulator_ready_o = ready_q;
    assign pkt_drop_o           = drop_q;
    assign beat_valid_o         = valid_q;
    assign beat_data_o          = data_q;
    assign beat_last_o          = last_q;

endmodule

// File: tb/tb_trdb_encapsulator.sv
// Scoreboard bench for trdb_encapsulator: expected beats queued at push, checked at handshake.
module tb_trdb_encapsulator;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         pkt_valid;
    logic [4:0]   pkt_length;
    logic [127:0] pkt_data;
    logic         enc_ready;
    logic         pkt_drop;
    logic [3:0]   fill;
    logic         beat_valid;
    logic [31:0]  beat_data;
    logic         beat_last;
    logic         beat_ready;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    vectors = 0;
    int    errors  = 0;

    logic        stall_q = 1'b0;
    logic [31:0] held_data;
    logic        held_last;

    trdb_encapsulator #(
        .PKT_W (128),
        .DEPTH (8),
        .OUT_W (32),
        .HI_WM (6),
        .LO_WM (2)
    ) dut (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .pkt_valid_i          (pkt_valid),
        .pkt_length_i         (pkt_length),
        .pkt_data_i           (pkt_data),
        .encapsulator_ready_o (enc_ready),
        .pkt_drop_o           (pkt_drop),
        .fill_o               (fill),
        .beat_valid_o         (beat_valid),
        .beat_data_o          (beat_data),
        .beat_last_o          (beat_last),
        .beat_ready_i         (beat_ready)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: stall stability and in-order beat content.
    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                vectors++;
                if (!beat_valid || beat_data !== held_data || beat_last !== held_last) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%0b data=%h last=%0b, want valid=1 data=%h last=%0b",
                             beat_valid, beat_data, beat_last, held_data, held_last);
                end
            end
            if (beat_valid && beat_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected: got data=%h last=%0b, want no beat", beat_data, beat_last);
                end else begin
                    e = exp_q.pop_front();
                    if (beat_data !== e.data || beat_last !== e.last) begin
                        errors++;
                        $display("FAIL beat_content: got data=%h last=%0b, want data=%h last=%0b",
                                 beat_data, beat_last, e.data, e.last);
                    end
                end
            end
            stall_q   = beat_valid && !beat_ready;
            held_data = beat_data;
            held_last = beat_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference framing: byte list, then packed four per beat.
    task automatic push_expected(input logic [4:0] len, input logic [127:0] data);
        logic [7:0] bytes [20];
        int         l;
        int         nb;
        beat_t      b;
        l = (len > 5'd16) ? 16 : int'(len);
        for (int i = 0; i < 20; i++) bytes[i] = 8'h00;
        bytes[0] = 8'(l);
        for (int i = 0; i < l; i++) bytes[i+1] = data[8*i +: 8];
        nb = (l + 1 + 3) / 4;
        for (int k = 0; k < nb; k++) begin
            b.data = {bytes[4*k+3], bytes[4*k+2], bytes[4*k+1], bytes[4*k]};
            b.last = (k == nb - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic send(input logic [4:0] len, input logic [127:0] data, input bit accept);
        pkt_valid  = 1'b1;
        pkt_length = len;
        pkt_data   = data;
        if (accept) push_expected(len, data);
        tick();
        pkt_valid  = 1'b0;
        pkt_length = 5'd0;
        pkt_data   = '0;
    endtask

    task automatic wait_drain(input int budget);
        int i;
        i = 0;
        while (i < budget && !(exp_q.size() == 0 && !beat_valid)) begin
            tick();
            i++;
        end
        vectors++;
        if (exp_q.size() != 0 || beat_valid) begin
            errors++;
            $display("FAIL drain_timeout: got %0d beats pending valid=%0b, want 0 pending valid=0",
                     exp_q.size(), beat_valid);
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b1;
        pkt_valid  = 1'b0;
        pkt_length = 5'd0;
        pkt_data   = '0;
        beat_ready = 1'b0;
        #2 rst_n = 1'b0;
        #2;
        vectors++;
        if (enc_ready !== 1'b1 || pkt_drop !== 1'b0 || fill !== 4'd0 ||
            beat_valid !== 1'b0 || beat_data !== 32'h0 || beat_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got rdy=%0b drop=%0b fill=%0d v=%0b d=%h l=%0b, want 1 0 0 0 0 0",
                     enc_ready, pkt_drop, fill, beat_valid, beat_data, beat_last);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        vectors++;
        if (enc_ready !== 1'b1 || beat_valid !== 1'b0 || fill !== 4'd0) begin
            errors++;
            $display("FAIL post_reset_idle: got rdy=%0b v=%0b fill=%0d, want 1 0 0", enc_ready, beat_valid, fill);
        end
    endtask

    task automatic test_single();
        beat_ready = 1'b1;
        send(5'd3, 128'hCCBBAA, 1'b1);
        vectors++;
        if (fill !== 4'd1 || beat_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_queued: got fill=%0d v=%0b, want fill=1 v=0", fill, beat_valid);
        end
        tick();
        vectors++;
        if (beat_valid !== 1'b1 || beat_data !== 32'hCCBBAA03 || beat_last !== 1'b1 || fill !== 4'd0) begin
            errors++;
            $display("FAIL single_beat: got v=%0b d=%h l=%0b fill=%0d, want 1 ccbbaa03 1 0",
                     beat_valid, beat_data, beat_last, fill);
        end
        wait_drain(10);
    endtask

    task automatic test_max();
        logic [127:0] d;
        for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(i + 1);
        beat_ready = 1'b1;
        send(5'd20, d, 1'b1);
        tick();
        vectors++;
        if (beat_valid !== 1'b1 || beat_data !== 32'h03020110 || beat_last !== 1'b0) begin
            errors++;
            $display("FAIL max_first_beat: got v=%0b d=%h l=%0b, want 1 03020110 0", beat_valid, beat_data, beat_last);
        end
        wait_drain(20);
    endtask

    task automatic test_fill();
        int  exp_f;
        bit  exp_r;
        beat_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            send(5'd1, 128'(i + 1), (i < 9));
            exp_f = (i == 0) ? 1 : ((i > 8) ? 8 : i);
            exp_r = (exp_f >= 6) ? 1'b0 : 1'b1;
            vectors++;
            if (fill !== 4'(exp_f) || enc_ready !== exp_r || pkt_drop !== (i == 9)) begin
                errors++;
                $display("FAIL fill_ramp[%0d]: got fill=%0d rdy=%0b drop=%0b, want %0d %0b %0b",
                         i, fill, enc_ready, pkt_drop, exp_f, exp_r, (i == 9));
            end
        end
        tick();
        vectors++;
        if (pkt_drop !== 1'b0 || fill !== 4'd8 || beat_valid !== 1'b1 || enc_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: got drop=%0b fill=%0d v=%0b rdy=%0b, want 0 8 1 0",
                     pkt_drop, fill, beat_valid, enc_ready);
        end
        beat_ready = 1'b1;
        exp_f = 8;
        exp_r = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            exp_f = (exp_f > 0) ? exp_f - 1 : 0;
            if (exp_f >= 6) exp_r = 1'b0;
            else if (exp_f <= 2) exp_r = 1'b1;
            vectors++;
            if (fill !== 4'(exp_f) || enc_ready !== exp_r || pkt_drop !== 1'b0) begin
                errors++;
                $display("FAIL fill_drain[%0d]: got fill=%0d rdy=%0b drop=%0b, want %0d %0b 0",
                         i, fill, enc_ready, pkt_drop, exp_f, exp_r);
            end
        end
        wait_drain(20);
    endtask

    task automatic test_backpressure();
        logic [127:0] d;
        int           i;
        d = {$urandom, $urandom, $urandom, $urandom};
        beat_ready = 1'b0;
        send(5'd16, d, 1'b1);
        i = 0;
        while (i < 80 && !(exp_q.size() == 0 && !beat_valid)) begin
            beat_ready = 1'($urandom_range(0, 1));
            tick();
            i++;
        end
        beat_ready = 1'b1;
        wait_drain(20);
    endtask

    task automatic test_back_to_back();
        int run;
        bit ended;
        bit bubble;
        beat_ready = 1'b0;
        send(5'd0, 128'hDEADBEEF, 1'b0);
        vectors++;
        if (fill !== 4'd0 || pkt_drop !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_push: got fill=%0d drop=%0b, want 0 0", fill, pkt_drop);
        end
        tick();
        vectors++;
        if (beat_valid !== 1'b0 || fill !== 4'd0) begin
            errors++;
            $display("FAIL zero_len_frame: got v=%0b fill=%0d, want 0 0", beat_valid, fill);
        end
        send(5'd5,  {$urandom, $urandom, $urandom, $urandom}, 1'b1);
        send(5'd16, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
        send(5'd2,  {$urandom, $urandom, $urandom, $urandom}, 1'b1);
        beat_ready = 1'b1;
        run    = 0;
        ended  = 1'b0;
        bubble = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (beat_valid) begin
                if (ended) bubble = 1'b1;
                run++;
            end else if (run > 0) begin
                ended = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        vectors++;
        if (run != 8 || bubble) begin
            errors++;
            $display("FAIL back_to_back: got run=%0d bubble=%0b, want run=8 bubble=0", run, bubble);
        end
        wait_drain(10);
    endtask

    task automatic test_midreset();
        logic [127:0] d;
        for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(8'hA0 + i);
        beat_ready = 1'b1;
        send(5'd16, d, 1'b1);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        vectors++;
        if (enc_ready !== 1'b1 || pkt_drop !== 1'b0 || fill !== 4'd0 ||
            beat_valid !== 1'b0 || beat_data !== 32'h0 || beat_last !== 1'b0) begin
            errors++;
            $display("FAIL midreset_values: got rdy=%0b drop=%0b fill=%0d v=%0b d=%h l=%0b, want 1 0 0 0 0 0",
                     enc_ready, pkt_drop, fill, beat_valid, beat_data, beat_last);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if (beat_valid !== 1'b0 || fill !== 4'd0) begin
                errors++;
                $display("FAIL midreset_resume[%0d]: got v=%0b fill=%0d, want 0 0", i, beat_valid, fill);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_max();
        test_fill();
        test_backpressure();
        test_back_to_back();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
